// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
// Shared types and default constants for the MAC sequencer.
//   mac_seq_state_t : controller state encoding
//   MAC_VEC_LEN     : default operand pairs per dot product
//   MAC_MULT_LAT    : default multiplier pipeline depth
//   MAC_FIFO_LAT    : default FIFO read latency
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mac_seq_state_t;

    localparam int MAC_VEC_LEN  = 8;
    localparam int MAC_MULT_LAT = 1;
    localparam int MAC_FIFO_LAT = 1;

endpackage : mac_ctrl_pkg

// File: rtl/valid_delay.sv
// valid_delay
// Depth-DEPTH shift register carrying one valid bit per issued operand pair.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears every stage
//   flush    : synchronous clear of every stage (wins over shifting)
//   din      : valid bit entering stage 1
//   dout     : valid bit leaving stage DEPTH
//   inflight : some valid bit sits in a stage other than the last one
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout,
    output logic inflight
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] shift_in;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign shift_in[gi] = din;
            end else begin : g_body
                assign shift_in[gi] = stage_reg[gi-1];
            end
        end

        // The last stage is the output tap; only the stages ahead of it
        // can still produce a future pulse.
        if (DEPTH > 1) begin : g_inflight
            assign inflight = |stage_reg[DEPTH-2:0];
        end else begin : g_no_inflight
            assign inflight = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else if (flush) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= shift_in;
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule : valid_delay

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequencer between the operand FIFOs and the MAC array. On start it clears
// the accumulators, pops exactly VEC_LEN operand pairs, and enables
// accumulation only when a valid product reaches the multiplier output.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : run request, sampled only when idle
//   abort      : synchronous cancel back to idle
//   fifo_empty : any operand FIFO empty
//   fifo_rden  : pop one entry from every operand FIFO
//   mac_clr    : accumulator clear to all lanes
//   mac_en     : accumulate enable to all lanes
//   busy       : controller not idle
//   done       : one-cycle pulse, results final
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int VEC_LEN  = MAC_VEC_LEN,
    parameter int MULT_LAT = MAC_MULT_LAT,
    parameter int FIFO_LAT = MAC_FIFO_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic fifo_empty,
    output logic fifo_rden,
    output logic mac_clr,
    output logic mac_en,
    output logic busy,
    output logic done
);

    localparam int DEPTH = FIFO_LAT + MULT_LAT;
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(VEC_LEN - 1);

    mac_seq_state_t   state_reg, state_next;
    logic [CNT_W-1:0] issue_cnt_reg, issue_cnt_next;
    logic             flush;
    logic             inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            issue_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        fifo_rden      = 1'b0;
        mac_clr        = 1'b0;
        flush          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                issue_cnt_next = '0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr    = 1'b1;
                state_next = ST_FEED;
            end
            ST_FEED: begin
                if (!fifo_empty) begin
                    fifo_rden      = 1'b1;
                    issue_cnt_next = issue_cnt_reg + 1'b1;
                    if (issue_cnt_reg == LAST_ISSUE) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the only remaining valid bit (if any) is
                // at the output tap: that is the final mac_en pulse, and it
                // fires this cycle while DONE follows on the next.
                if (!inflight) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Cancel overrides everything. The pop is also held back so an
        // aborted run does not throw away one more entry than necessary.
        if (abort) begin
            state_next     = ST_IDLE;
            issue_cnt_next = '0;
            flush          = 1'b1;
            fifo_rden      = 1'b0;
        end
    end

    valid_delay #(
        .DEPTH(DEPTH)
    ) u_valid_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .din      (fifo_rden),
        .dout     (mac_en),
        .inflight (inflight)
    );

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

endmodule : mac_seq_ctrl

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
// Scoreboard bench: each run pushes the cycles at which mac_clr, fifo_rden,
// mac_en and done must fire, plus the expected accumulator value, into
// queues; a negedge monitor pops and compares as the DUT asserts them.
module tb_mac_seq_ctrl;

    localparam int VL = 8;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic fifo_empty = 1'b1;
    logic fifo_rden, mac_clr, mac_en, busy, done;

    logic start2 = 1'b0;
    logic abort2 = 1'b0;
    logic fifo_empty2 = 1'b0;
    logic rden2, clr2, en2, busy2, done2;

    mac_seq_ctrl #(.VEC_LEN(VL), .MULT_LAT(1), .FIFO_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .busy       (busy),
        .done       (done)
    );

    mac_seq_ctrl #(.VEC_LEN(1), .MULT_LAT(3), .FIFO_LAT(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .abort      (abort2),
        .fifo_empty (fifo_empty2),
        .fifo_rden  (rden2),
        .mac_clr    (clr2),
        .mac_en     (en2),
        .busy       (busy2),
        .done       (done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int exp_clr_q[$];
    int exp_rden_q[$];
    int exp_en_q[$];
    int exp_done_q[$];
    int exp_cout_q[$];
    int fifo_a_q[$];
    int prod_q[$];
    int acc = 0;
    int opb = 2;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic ev_check(input string name, input logic sig, ref int q[$]);
        while (q.size() > 0 && q[0] < cyc) begin
            chk({name, "_missing"}, 0, 1);
            void'(q.pop_front());
        end
        if (sig) begin
            if (q.size() == 0) chk({name, "_unexpected"}, 1, 0);
            else               chk({name, "_cycle"}, cyc, q.pop_front());
        end
    endtask

    // Monitor: compares DUT events against the scoreboard and runs a
    // behavioural FIFO + multiplier + accumulator driven by the DUT strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            ev_check("mac_clr", mac_clr, exp_clr_q);
            ev_check("fifo_rden", fifo_rden, exp_rden_q);
            ev_check("mac_en", mac_en, exp_en_q);
            ev_check("done", done, exp_done_q);
            chk("clr_en_overlap", int'(mac_clr & mac_en), 0);
            chk("rden_while_empty", int'(fifo_rden & fifo_empty), 0);
            if (mac_clr) acc = 0;
            if (fifo_rden) begin
                if (fifo_a_q.size() == 0) chk("fifo_underflow", 0, 1);
                else prod_q.push_back(fifo_a_q.pop_front() * opb);
            end
            if (mac_en) begin
                if (prod_q.size() == 0) chk("product_avail", 0, 1);
                else acc += prod_q.pop_front();
            end
            if (done) begin
                if (exp_cout_q.size() == 0) chk("cout_unexpected", 1, 0);
                else chk("cout", acc, exp_cout_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: A=1..8, B=2, no stalls; 1: random data and stalls;
    // 2: A=1..8, B=2, three empty cycles after the third pop.
    // abort_at < 0 means no abort; extra_start pulses start while busy.
    task automatic run_op(input int mode, input int abort_at, input bit extra_start);
        int s;
        int a;
        int last;
        int done_c;
        int end_c;
        int n;
        int sum;
        int rc[VL];
        bit stall[64];

        s = cyc;
        a = (abort_at >= 0) ? s + abort_at : 1 << 30;
        for (int i = 0; i < 64; i++) begin
            if (mode == 1)      stall[i] = (i < 40) && ($urandom_range(3) == 0);
            else if (mode == 2) stall[i] = (i >= 3 && i < 6);
            else                stall[i] = 1'b0;
        end
        n = 0;
        for (int i = 0; i < 64 && n < VL; i++) begin
            if (!stall[i]) begin
                rc[n] = s + 2 + i;
                n++;
            end
        end
        last   = rc[VL-1];
        done_c = last + D + 1;

        fifo_a_q.delete();
        prod_q.delete();
        opb = (mode == 1) ? int'($urandom_range(1, 15)) : 2;
        sum = 0;
        for (int k = 0; k < VL; k++) begin
            int av;
            av = (mode == 1) ? int'($urandom_range(1, 255)) : k + 1;
            fifo_a_q.push_back(av);
            sum += av * opb;
        end

        if (s + 1 <= a) exp_clr_q.push_back(s + 1);
        for (int k = 0; k < VL; k++) begin
            if (rc[k] < a)      exp_rden_q.push_back(rc[k]);
            if (rc[k] + D <= a) exp_en_q.push_back(rc[k] + D);
        end
        if (abort_at < 0) begin
            exp_done_q.push_back(done_c);
            exp_cout_q.push_back(sum);
        end
        end_c = (abort_at >= 0) ? a : done_c;

        for (int c = s; c <= end_c; c++) begin
            start = (c == s) || (extra_start && c == s + 4);
            abort = (c == a);
            if (c < s + 2)      fifo_empty = 1'b0;
            else if (c > last)  fifo_empty = 1'b1;
            else                fifo_empty = stall[c - s - 2];
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        fifo_empty = 1'b1;
        chk("busy_after_run", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s2, rc2, ec2, dc2, cc2, nr2, ne2, nd2;
        int s;

        repeat (3) tick();
        chk("reset_outputs", int'({fifo_rden, mac_clr, mac_en, busy, done}), 0);
        chk("reset_outputs_dut2", int'({rden2, clr2, en2, busy2, done2}), 0);
        rst_n = 1'b1;
        tick();

        // MULT_LAT=3, VEC_LEN=1 instance: one pop, mac_en 4 cycles later.
        s2 = cyc;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        rc2 = -1; ec2 = -1; dc2 = -1; cc2 = -1; nr2 = 0; ne2 = 0; nd2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (clr2)  cc2 = cyc;
            if (rden2) begin rc2 = cyc; nr2++; end
            if (en2)   begin ec2 = cyc; ne2++; end
            if (done2) begin dc2 = cyc; nd2++; end
            tick();
        end
        chk("dut2_clr_cycle", cc2 - s2, 1);
        chk("dut2_rden_cycle", rc2 - s2, 2);
        chk("dut2_rden_count", nr2, 1);
        chk("dut2_en_count", ne2, 1);
        chk("dut2_en_delay", ec2 - rc2, 4);
        chk("dut2_done_count", nd2, 1);
        chk("dut2_done_delay", dc2 - ec2, 1);
        chk("dut2_busy_idle", int'(busy2), 0);

        // Directed: no stalls, then a 3-cycle stall after the third pop.
        run_op(0, -1, 1'b0);
        run_op(2, -1, 1'b0);
        // Abort at cycle 6, then a clean run right after.
        run_op(0, 6, 1'b0);
        run_op(0, -1, 1'b0);

        // start and abort together while idle: nothing happens.
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) tick();
        chk("start_abort_idle_busy", int'(busy), 0);

        // Asynchronous reset at cycle 5 of a run.
        s = cyc;
        fifo_a_q.delete();
        prod_q.delete();
        opb = 2;
        for (int k = 0; k < VL; k++) fifo_a_q.push_back(k + 1);
        exp_clr_q.push_back(s + 1);
        for (int k = 2; k < 5; k++) exp_rden_q.push_back(s + k);
        exp_en_q.push_back(s + 4);
        for (int c = s; c < s + 5; c++) begin
            start = (c == s);
            fifo_empty = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", int'({fifo_rden, mac_clr, mac_en, busy, done}), 0);
        exp_clr_q.delete();
        exp_rden_q.delete();
        exp_en_q.delete();
        exp_done_q.delete();
        exp_cout_q.delete();
        prod_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("after_reset_busy", int'(busy), 0);
        fifo_empty = 1'b1;

        // Ignored start while busy, then back-to-back starts.
        run_op(0, -1, 1'b1);
        run_op(1, -1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int ab;
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(1, 10)) : -1;
            run_op(1, ab, (ab < 0) && ($urandom_range(1) == 1));
            repeat ($urandom_range(3)) tick();
        end

        repeat (5) tick();
        chk("leftover_expected",
            exp_clr_q.size() + exp_rden_q.size() + exp_en_q.size() +
            exp_done_q.size() + exp_cout_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mac_seq_ctrl

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the MAC datapath: on `start` it clears the accumulator, streams exactly `VEC_LEN` operand pairs out of the input FIFOs into the multiplier, and asserts the MAC enable only on cycles where a valid product sits at the multiplier output. It sits between the operand FIFOs and the MAC array. One controller drives the shared `mac_en`/`mac_clr` of every MAC lane in lockstep. It raises `done` once the final product has been accumulated.

## Interface

Parameters:
- `VEC_LEN`, 8: operand pairs per dot product; must be ≥1.
- `MULT_LAT`, 1: multiplier pipeline depth in cycles; must be ≥1.
- `FIFO_LAT`, 1: cycles from `fifo_rden` to operand valid at the multiplier input.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; returns to IDLE next cycle.
- `fifo_empty` in 1: OR of all operand FIFO empties.
- `fifo_rden` out 1: pops one entry from every operand FIFO.
- `mac_clr` out 1: accumulator clear to all MAC lanes.
- `mac_en` out 1: accumulate enable to all MAC lanes.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the results are final.

## Operation

- States are IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 moves to CLEAR.
- CLEAR:
  - Drives `mac_clr`=1 for exactly one cycle, then moves to FEED.
- FEED:
  - `fifo_rden` = !`fifo_empty`; each asserted `fifo_rden` counts one issue.
  - `fifo_rden` is never asserted while `fifo_empty`=1.
  - When the issue count reaches `VEC_LEN`, `fifo_rden` drops and the state moves to DRAIN.
  - Issue counter width is clog2(`VEC_LEN`+1).
- Valid pipeline:
  - A shift register of depth D = `FIFO_LAT`+`MULT_LAT` carries each issue.
  - `mac_en` is the tap at stage D, so it is high exactly D cycles after each `fifo_rden` pulse.
  - FIFO-empty stalls become bubbles in the pipeline, and `mac_en` is low for those cycles.
- DRAIN:
  - Waits until the valid pipeline is all-zero, then moves to DONE.
  - The last `mac_en` pulse occurs during DRAIN.
- DONE:
  - `done`=1 for one cycle, then returns to IDLE.
  - MAC results are stable and readable from this cycle until the next CLEAR.
- Invariant: exactly `VEC_LEN` `mac_en` pulses occur between `mac_clr` and `done`.
- `start` outside IDLE is ignored, not queued.
- `abort`:
  - Has priority over all transitions.
  - Next state is IDLE, the valid pipeline and counter are zeroed, and no `done` pulse is produced.
  - Entries already popped are lost.
- `start` and `abort` asserted in the same cycle in IDLE leaves the block in IDLE.

## Timing

- Reset values: state IDLE, counter 0, pipeline 0, and every output 0.
- Reset mid-operation takes effect immediately (asynchronous); no pulse follows deassertion.
- With default parameters (D=2) and no stalls, counting `start` as cycle 0:
  - cycle 1: CLEAR, `mac_clr`=1.
  - cycles 2..9: `fifo_rden`=1.
  - cycles 4..11: `mac_en`=1.
  - cycle 12: `done`=1.
- No-stall latency from `start` to `done` is 2+`VEC_LEN`+D cycles.
- `mac_clr` and `mac_en` are never high in the same cycle.
- The first `fifo_rden` comes one cycle after `mac_clr`.
- Back-to-back operation: `start` in the cycle after `done` is accepted.

## Structure

- Package `mac_ctrl_pkg` holds:
  - the state enum `mac_seq_state_t`;
  - default constants `MAC_VEC_LEN`=8, `MAC_MULT_LAT`=1, `MAC_FIFO_LAT`=1.
- Sub-module `valid_delay`: parameterised depth-D shift register with synchronous flush and async reset.
  - Instantiated once for the issue→`mac_en` pipeline.
- The FSM and issue counter are in the top level.

## Test plan

- Default parameters, FIFOs preloaded with 8 entries (A=1..8, B=2), `start` → `mac_clr` at cycle 1, 8 `mac_en` pulses at cycles 4..11, `done` at cycle 12, MAC Cout=72.
- `fifo_empty` forced high for 3 cycles after the 3rd pop → 3-cycle bubble in `mac_en`, `done` at cycle 15, still exactly 8 pulses, Cout=72.
- `abort` at cycle 6 → IDLE at cycle 7, `mac_en` stays low from cycle 7 on, no `done`; then a new `start` yields a clean full run.
- `rst_n` low at cycle 5 → all outputs 0 immediately, state IDLE; no `done` after release.
- `start` pulsed while busy, and again the cycle after `done` → the first is ignored; the second starts a run whose `mac_clr` comes 1 cycle later.
- `MULT_LAT`=3, `VEC_LEN`=1 → `mac_en` exactly 4 cycles after the single `fifo_rden`, `done` 1 cycle after `mac_en`.
